// File: rtl/sdram_ctrl_single_if.sv
// Avalon-MM style single-word request/response bus facing the SDRAM controller.
// Latency: n/a (signal bundle only).
// Backpressure: the slave holds off requests with az_waitrequest.
interface sdram_ctrl_single_if;
    logic [23:0] az_addr;
    logic [15:0] az_wr_data;
    logic [1:0]  az_be_n;
    logic        az_rd;
    logic        az_wr;
    logic        az_waitrequest;
    logic [15:0] az_readdata;
    logic        az_readdatavalid;

    modport master (
        output az_addr, az_wr_data, az_be_n, az_rd, az_wr,
        input  az_waitrequest, az_readdata, az_readdatavalid
    );

    modport slave (
        input  az_addr, az_wr_data, az_be_n, az_rd, az_wr,
        output az_waitrequest, az_readdata, az_readdatavalid
    );
endinterface

// File: rtl/sdram_ctrl_single.sv
// Single-port closed-page SDRAM controller: init, auto-refresh, single-word ACT/RD|WR/PRE.
// Latency: read strobe in the cycle after edge accept+T_RCD+1+CAS_LATENCY; all zs_* pins registered.
// Backpressure: az_waitrequest is low only in IDLE with no refresh pending; one access at a time.
module sdram_ctrl_single #(
    parameter int CAS_LATENCY    = 3,
    parameter int INIT_WAIT      = 5000,
    parameter int REFRESH_PERIOD = 390,
    parameter int T_RP           = 2,
    parameter int T_RFC          = 7,
    parameter int T_RCD          = 2,
    parameter int T_MRD          = 2,
    parameter int T_WR           = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sdram_ctrl_single_if.slave   az,
    output logic [12:0]          zs_addr,
    output logic [1:0]           zs_ba,
    output logic                 zs_cs_n,
    output logic                 zs_ras_n,
    output logic                 zs_cas_n,
    output logic                 zs_we_n,
    output logic                 zs_cke,
    output logic [1:0]           zs_dqm,
    inout  wire  [15:0]          zs_dq
);

    // FSM state encodings
    localparam logic [3:0] ST_INIT_WAIT = 4'd0;
    localparam logic [3:0] ST_INIT_PRE  = 4'd1;
    localparam logic [3:0] ST_INIT_REF1 = 4'd2;
    localparam logic [3:0] ST_INIT_REF2 = 4'd3;
    localparam logic [3:0] ST_INIT_LMR  = 4'd4;
    localparam logic [3:0] ST_IDLE      = 4'd5;
    localparam logic [3:0] ST_REFRESH   = 4'd6;
    localparam logic [3:0] ST_ACTIVATE  = 4'd7;
    localparam logic [3:0] ST_ISSUE     = 4'd8;
    localparam logic [3:0] ST_PRECHARGE = 4'd9;
    localparam logic [3:0] ST_WAIT      = 4'd10;

    // Command pins {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_LMR  = 4'b0000;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_INH  = 4'b1111;

    localparam logic [15:0] INIT_RELOAD = 16'(INIT_WAIT - 1);
    localparam logic [15:0] REF_RELOAD  = 16'(REFRESH_PERIOD - 1);
    // Write burst = single, sequential, burst length 1
    localparam logic [12:0] MODE_WORD   = {3'b000, 1'b1, 2'b00, 3'(CAS_LATENCY), 1'b0, 3'b000};

    logic [3:0]             state_q, state_d;
    logic [3:0]             ret_q, ret_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   ref_en_q, ref_en_d;
    logic [15:0]            ref_cnt_q, ref_cnt_d;
    logic                   ref_pend_q, ref_pend_d;
    logic [3:0]             cmd_q, cmd_d;
    logic [12:0]            addr_q, addr_d;
    logic [1:0]             ba_q, ba_d;
    logic [1:0]             dqm_q, dqm_d;
    logic                   dq_oe_q, dq_oe_d;
    logic [15:0]            dq_out_q, dq_out_d;
    logic                   cke_q, cke_d;
    logic [23:0]            req_addr_q, req_addr_d;
    logic [15:0]            req_data_q, req_data_d;
    logic [1:0]             req_be_q, req_be_d;
    logic                   req_wr_q, req_wr_d;
    logic [CAS_LATENCY:0]   rd_pipe_q, rd_pipe_d;
    logic [15:0]            rdata_q, rdata_d;
    logic                   rdv_q, rdv_d;

    logic                   ref_clr;
    logic                   rd_issue;
    logic                   go_vld;
    logic [3:0]             go_state;
    int                     go_gap;

    // Main sequencer: picks this cycle's command and the next state, then inserts timing gaps
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        cnt_d      = cnt_q;
        cmd_d      = CMD_NOP;
        addr_d     = addr_q;
        ba_d       = ba_q;
        dqm_d      = 2'b11;
        dq_oe_d    = 1'b0;
        dq_out_d   = dq_out_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        req_be_d   = req_be_q;
        req_wr_d   = req_wr_q;
        ref_clr    = 1'b0;
        rd_issue   = 1'b0;
        go_vld     = 1'b0;
        go_state   = ST_IDLE;
        go_gap     = 0;

        case (state_q)
            ST_INIT_WAIT: begin
                cmd_d = CMD_NOP;
                if (cnt_q == 16'd0) state_d = ST_INIT_PRE;
                else                cnt_d   = cnt_q - 16'd1;
            end
            ST_INIT_PRE: begin
                cmd_d    = CMD_PRE;
                addr_d   = 13'h0400;
                ba_d     = 2'b00;
                go_vld   = 1'b1;
                go_state = ST_INIT_REF1;
                go_gap   = T_RP;
            end
            ST_INIT_REF1: begin
                cmd_d    = CMD_AREF;
                go_vld   = 1'b1;
                go_state = ST_INIT_REF2;
                go_gap   = T_RFC;
            end
            ST_INIT_REF2: begin
                cmd_d    = CMD_AREF;
                go_vld   = 1'b1;
                go_state = ST_INIT_LMR;
                go_gap   = T_RFC;
            end
            ST_INIT_LMR: begin
                cmd_d    = CMD_LMR;
                addr_d   = MODE_WORD;
                ba_d     = 2'b00;
                go_vld   = 1'b1;
                go_state = ST_IDLE;
                go_gap   = T_MRD;
            end
            ST_IDLE: begin
                cmd_d = CMD_INH;
                if (ref_pend_q) begin
                    // Refresh wins over any waiting request
                    cmd_d    = CMD_AREF;
                    ref_clr  = 1'b1;
                    go_vld   = 1'b1;
                    go_state = ST_IDLE;
                    go_gap   = T_RFC;
                end else if (az.az_rd || az.az_wr) begin
                    // Write takes precedence when both strobes are high
                    req_addr_d = az.az_addr;
                    req_data_d = az.az_wr_data;
                    req_be_d   = az.az_be_n;
                    req_wr_d   = az.az_wr;
                    cmd_d      = CMD_ACT;
                    ba_d       = {az.az_addr[23], az.az_addr[9]};
                    addr_d     = az.az_addr[22:10];
                    go_vld     = 1'b1;
                    go_state   = ST_ISSUE;
                    go_gap     = T_RCD;
                end
            end
            ST_ISSUE: begin
                ba_d   = {req_addr_q[23], req_addr_q[9]};
                addr_d = {4'b0000, req_addr_q[8:0]};
                go_vld = 1'b1;
                go_state = ST_PRECHARGE;
                if (req_wr_q) begin
                    cmd_d    = CMD_WR;
                    dq_oe_d  = 1'b1;
                    dq_out_d = req_data_q;
                    dqm_d    = req_be_q;
                    go_gap   = T_WR;
                end else begin
                    // PRE lands one cycle after the data capture edge
                    cmd_d    = CMD_RD;
                    dqm_d    = 2'b00;
                    rd_issue = 1'b1;
                    go_gap   = CAS_LATENCY + 2;
                end
            end
            ST_PRECHARGE: begin
                cmd_d    = CMD_PRE;
                addr_d   = 13'h0000;
                go_vld   = 1'b1;
                go_state = ST_IDLE;
                go_gap   = T_RP;
            end
            ST_WAIT: begin
                cmd_d = CMD_NOP;
                if (cnt_q == 16'd0) state_d = ret_q;
                else                cnt_d   = cnt_q - 16'd1;
            end
            default: begin
                cmd_d   = CMD_INH;
                state_d = ST_INIT_WAIT;
                cnt_d   = INIT_RELOAD;
            end
        endcase

        // Keep the data mask open while read data is still on its way back
        if (rd_pipe_q[CAS_LATENCY-1:0] != '0) dqm_d = 2'b00;

        // A gap of g cycles means g-1 NOP cycles before the follow-on state's command
        if (go_vld) begin
            if (go_gap <= 1) begin
                state_d = go_state;
            end else begin
                state_d = ST_WAIT;
                ret_d   = go_state;
                cnt_d   = 16'(go_gap - 2);
            end
        end
    end

    // Refresh timer: armed on first IDLE entry, raises a pending request every REFRESH_PERIOD clocks
    always_comb begin
        ref_en_d   = ref_en_q;
        ref_cnt_d  = ref_cnt_q;
        ref_pend_d = ref_pend_q;
        if (ref_clr) ref_pend_d = 1'b0;
        if (!ref_en_q) begin
            if (state_q == ST_IDLE) begin
                ref_en_d  = 1'b1;
                ref_cnt_d = REF_RELOAD;
            end
        end else if (ref_cnt_q == 16'd0) begin
            ref_cnt_d  = REF_RELOAD;
            ref_pend_d = 1'b1;
        end else begin
            ref_cnt_d = ref_cnt_q - 16'd1;
        end
    end

    // Read return path: a token travels CAS_LATENCY+1 stages from RD issue to the capture edge
    always_comb begin
        rd_pipe_d = {rd_pipe_q[CAS_LATENCY-1:0], rd_issue};
        rdv_d     = rd_pipe_q[CAS_LATENCY];
        rdata_d   = rd_pipe_q[CAS_LATENCY] ? zs_dq : rdata_q;
        cke_d     = 1'b1;
    end

    // State and pin registers; reset forces pins idle and restarts initialisation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_INIT_WAIT;
            ret_q      <= ST_IDLE;
            cnt_q      <= INIT_RELOAD;
            ref_en_q   <= 1'b0;
            ref_cnt_q  <= 16'd0;
            ref_pend_q <= 1'b0;
            cmd_q      <= CMD_INH;
            addr_q     <= 13'h0000;
            ba_q       <= 2'b00;
            dqm_q      <= 2'b11;
            dq_oe_q    <= 1'b0;
            dq_out_q   <= 16'h0000;
            cke_q      <= 1'b0;
            req_addr_q <= 24'h000000;
            req_data_q <= 16'h0000;
            req_be_q   <= 2'b11;
            req_wr_q   <= 1'b0;
            rd_pipe_q  <= '0;
            rdata_q    <= 16'h0000;
            rdv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            cnt_q      <= cnt_d;
            ref_en_q   <= ref_en_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            ba_q       <= ba_d;
            dqm_q      <= dqm_d;
            dq_oe_q    <= dq_oe_d;
            dq_out_q   <= dq_out_d;
            cke_q      <= cke_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            req_be_q   <= req_be_d;
            req_wr_q   <= req_wr_d;
            rd_pipe_q  <= rd_pipe_d;
            rdata_q    <= rdata_d;
            rdv_q      <= rdv_d;
        end
    end

    assign {zs_cs_n, zs_ras_n, zs_cas_n, zs_we_n} = cmd_q;
    assign zs_addr = addr_q;
    assign zs_ba   = ba_q;
    assign zs_dqm  = dqm_q;
    assign zs_cke  = cke_q;
    assign zs_dq   = dq_oe_q ? dq_out_q : 16'hzzzz;

    assign az.az_waitrequest   = !((state_q == ST_IDLE) && !ref_pend_q);
    assign az.az_readdata      = rdata_q;
    assign az.az_readdatavalid = rdv_q;

endmodule

// File: tb/tb_sdram_ctrl_single.sv
// Scoreboard bench for sdram_ctrl_single with a behavioural SDRAM model on the zs_* pins.
// Latency: expected read strobe cycle is computed at request acceptance.
// Backpressure: the driver holds each request until az_waitrequest is low.
module tb_sdram_ctrl_single;
    localparam int CL        = 3;
    localparam int INIT_WAIT = 5000;
    localparam int REF_PER   = 390;
    localparam int T_RCD     = 2;
    localparam int REF_TOL   = 12;

    localparam logic [3:0] C_LMR  = 4'b0000;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_NOP  = 4'b0111;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sdram_ctrl_single_if az_if();
    logic [12:0] zs_addr;
    logic [1:0]  zs_ba, zs_dqm;
    logic        zs_cs_n, zs_ras_n, zs_cas_n, zs_we_n, zs_cke;
    wire  [15:0] zs_dq;
    logic        model_oe = 1'b0;
    logic [15:0] model_dat = 16'h0000;
    assign zs_dq = model_oe ? model_dat : 16'hzzzz;

    sdram_ctrl_single dut (
        .clk(clk), .reset_n(reset_n), .az(az_if.slave),
        .zs_addr(zs_addr), .zs_ba(zs_ba), .zs_cs_n(zs_cs_n), .zs_ras_n(zs_ras_n),
        .zs_cas_n(zs_cas_n), .zs_we_n(zs_we_n), .zs_cke(zs_cke), .zs_dqm(zs_dqm), .zs_dq(zs_dq)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_strobe = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- SDRAM model ----------------
    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic [15:0] dq;
        logic [1:0]  dqm;
        int          nops;
    } cmd_rec_t;

    cmd_rec_t    cmd_log[$];
    logic [15:0] mem [logic [23:0]];
    logic [12:0] open_row [4];
    int          nop_run = 0;
    int          rd_cnt = 0;

    always @(posedge clk) begin
        logic [3:0]  c;
        logic [23:0] key;
        logic [15:0] w;
        cmd_rec_t    r;
        if (!reset_n) begin
            rd_cnt   <= 0;
            model_oe <= 1'b0;
        end else begin
            if (rd_cnt != 0) begin
                rd_cnt   <= rd_cnt - 1;
                model_oe <= (rd_cnt == 2);
            end
            if (zs_cke && !zs_cs_n) begin
                c = {zs_cs_n, zs_ras_n, zs_cas_n, zs_we_n};
                if (c == C_NOP) begin
                    nop_run++;
                end else begin
                    key = {zs_ba, open_row[zs_ba], zs_addr[8:0]};
                    if (c == C_ACT) open_row[zs_ba] = zs_addr;
                    if (c == C_WR) begin
                        w = mem.exists(key) ? mem[key] : 16'h0000;
                        if (!zs_dqm[0]) w[7:0]  = zs_dq[7:0];
                        if (!zs_dqm[1]) w[15:8] = zs_dq[15:8];
                        mem[key] = w;
                    end
                    if (c == C_RD) begin
                        rd_cnt    <= CL;
                        model_dat <= mem.exists(key) ? mem[key] : 16'h0000;
                    end
                    r.cyc = cyc; r.cmd = c; r.ba = zs_ba; r.addr = zs_addr;
                    r.dq = zs_dq; r.dqm = zs_dqm; r.nops = nop_run;
                    cmd_log.push_back(r);
                    nop_run = 0;
                end
            end
        end
    end

    function automatic int count_cmd(input logic [3:0] c);
        int n = 0;
        foreach (cmd_log[i]) if (cmd_log[i].cmd == c) n++;
        return n;
    endfunction

    // ---------------- Scoreboard ----------------
    typedef struct { logic [15:0] dat; int cyc; } exp_t;
    exp_t exp_q[$];

    always @(negedge clk) begin
        exp_t e;
        if (az_if.az_readdatavalid) begin
            n_strobe++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_strobe: got strobe with data %h at cycle %0d, expected none", az_if.az_readdata, cyc);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", az_if.az_readdata, e.dat);
                check("rd_latency_cycle", cyc, e.cyc);
            end
        end
    end

    // ---------------- Driver ----------------
    task automatic access(input logic rd, input logic wr, input logic [23:0] a,
                          input logic [15:0] d, input logic [1:0] be, input logic [15:0] exp_rd);
        exp_t e;
        int   t = 0;
        @(negedge clk);
        az_if.az_addr = a; az_if.az_wr_data = d; az_if.az_be_n = be;
        az_if.az_rd = rd; az_if.az_wr = wr;
        while (az_if.az_waitrequest && t < 200) begin @(negedge clk); t++; end
        if (az_if.az_waitrequest) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: waitrequest still high after %0d cycles, expected low", t);
        end else if (rd && !wr) begin
            e.dat = exp_rd;
            e.cyc = cyc + 1 + T_RCD + 1 + CL;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        az_if.az_rd = 1'b0; az_if.az_wr = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (az_if.az_waitrequest && t < INIT_WAIT + 200) begin @(negedge clk); t++; end
        check("reach_idle", az_if.az_waitrequest, 1'b0);
    endtask

    task automatic check_init(input int base);
        check("init_pre_present", cmd_log.size() >= base + 4, 1'b1);
        if (cmd_log.size() >= base + 4) begin
            check("init_nops", cmd_log[base].nops, INIT_WAIT);
            check("init_pre_cmd", cmd_log[base].cmd, C_PRE);
            check("init_pre_a10", cmd_log[base].addr[10], 1'b1);
            check("init_ref1", cmd_log[base+1].cmd, C_AREF);
            check("init_ref2", cmd_log[base+2].cmd, C_AREF);
            check("init_lmr", cmd_log[base+3].cmd, C_LMR);
            check("init_lmr_addr", cmd_log[base+3].addr, 13'h0230);
            check("init_lmr_ba", cmd_log[base+3].ba, 2'b00);
        end
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_cke"}, zs_cke, 1'b0);
        check({tag, "_cmd"}, {zs_cs_n, zs_ras_n, zs_cas_n, zs_we_n}, 4'hF);
        check({tag, "_addr"}, zs_addr, 13'h0);
        check({tag, "_ba"}, zs_ba, 2'b00);
        check({tag, "_dqm"}, zs_dqm, 2'b11);
        check({tag, "_waitreq"}, az_if.az_waitrequest, 1'b1);
        check({tag, "_rdv"}, az_if.az_readdatavalid, 1'b0);
        check({tag, "_rdata"}, az_if.az_readdata, 16'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc, n_aref, prev, t, strobes_before;
        logic ok;
        az_if.az_addr = '0; az_if.az_wr_data = '0; az_if.az_be_n = 2'b11;
        az_if.az_rd = 1'b0; az_if.az_wr = 1'b0;

        // Reset values and init order
        repeat (3) @(negedge clk);
        check_reset_pins("reset");
        reset_n = 1'b1;
        wait_idle();
        check("cke_after_init", zs_cke, 1'b1);
        check("init_cmd_count", cmd_log.size(), 4);
        check_init(0);

        // Write BEEF, read back, check pin-level addressing
        cmd_log.delete();
        access(1'b0, 1'b1, 24'h812345, 16'hBEEF, 2'b00, 16'h0);
        access(1'b1, 1'b0, 24'h812345, 16'h0, 2'b11, 16'hBEEF);
        repeat (20) @(negedge clk);
        check("wr_rd_cmd_count", cmd_log.size(), 6);
        if (cmd_log.size() >= 6) begin
            check("act_cmd", cmd_log[0].cmd, C_ACT);
            check("act_ba", cmd_log[0].ba, 2'b11);
            check("act_row", cmd_log[0].addr, 13'h0048);
            check("wr_cmd", cmd_log[1].cmd, C_WR);
            check("wr_col", cmd_log[1].addr, 13'h0145);
            check("wr_dq", cmd_log[1].dq, 16'hBEEF);
            check("wr_dqm", cmd_log[1].dqm, 2'b00);
            check("wr_pre_cmd", cmd_log[2].cmd, C_PRE);
            check("wr_pre_a10", cmd_log[2].addr[10], 1'b0);
            check("wr_pre_ba", cmd_log[2].ba, 2'b11);
            check("rd_cmd", cmd_log[4].cmd, C_RD);
            check("rd_dqm", cmd_log[4].dqm, 2'b00);
            check("rd_pre_cmd", cmd_log[5].cmd, C_PRE);
        end

        // Byte-masked write over existing data
        access(1'b0, 1'b1, 24'h812345, 16'h1234, 2'b10, 16'h0);
        access(1'b1, 1'b0, 24'h812345, 16'h0, 2'b11, 16'hBE34);
        repeat (20) @(negedge clk);

        // Read and write together: write wins, no strobe
        cmd_log.delete();
        access(1'b1, 1'b1, 24'h000010, 16'h5A5A, 2'b00, 16'h0);
        repeat (15) @(negedge clk);
        check("rdwr_only_wr", count_cmd(C_WR), 1);
        check("rdwr_no_rd", count_cmd(C_RD), 0);
        access(1'b1, 1'b0, 24'h000010, 16'h0, 2'b11, 16'h5A5A);
        repeat (20) @(negedge clk);

        // Continuous read pressure across several refresh periods
        cmd_log.delete();
        n_acc = 0;
        @(negedge clk);
        az_if.az_addr = 24'h812345; az_if.az_rd = 1'b1; az_if.az_wr = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            exp_t e;
            if (i > 0) @(negedge clk);
            if (!az_if.az_waitrequest) begin
                e.dat = 16'hBE34;
                e.cyc = cyc + 1 + T_RCD + 1 + CL;
                exp_q.push_back(e);
                n_acc++;
            end
        end
        @(posedge clk); #1;
        az_if.az_rd = 1'b0;
        repeat (20) @(negedge clk);
        check("hold_drained", exp_q.size(), 0);
        check("hold_rd_cmds", count_cmd(C_RD), n_acc);
        check("hold_act_cmds", count_cmd(C_ACT), n_acc);
        n_aref = count_cmd(C_AREF);
        check("hold_aref_enough", n_aref >= 4, 1'b1);
        prev = -1;
        foreach (cmd_log[i]) begin
            if (cmd_log[i].cmd == C_AREF) begin
                if (prev >= 0) begin
                    t = cmd_log[i].cyc - prev;
                    ok = (t >= REF_PER - REF_TOL) && (t <= REF_PER + REF_TOL);
                    n_cmp++;
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL aref_interval: got %0d cycles, expected %0d +/- %0d", t, REF_PER, REF_TOL);
                    end
                end
                prev = cmd_log[i].cyc;
            end
        end

        // Reset between ACT and RD
        cmd_log.delete();
        strobes_before = n_strobe;
        @(negedge clk);
        az_if.az_addr = 24'h812345; az_if.az_rd = 1'b1;
        t = 0;
        while (az_if.az_waitrequest && t < 200) begin @(negedge clk); t++; end
        check("rst_accept", az_if.az_waitrequest, 1'b0);
        @(posedge clk); #1;
        az_if.az_rd = 1'b0;
        t = 0;
        while (count_cmd(C_ACT) == 0 && t < 10) begin @(posedge clk); #1; t++; end
        check("rst_act_seen", count_cmd(C_ACT), 1);
        reset_n = 1'b0;
        #1;
        check_reset_pins("async_reset");
        repeat (4) @(negedge clk);
        check("rst_no_rd", count_cmd(C_RD), 0);
        reset_n = 1'b1;
        wait_idle();
        check("reinit_cmd_count", cmd_log.size(), 5);
        check_init(1);
        repeat (10) @(negedge clk);
        check("rst_no_strobe", n_strobe, strobes_before);
        access(1'b1, 1'b0, 24'h812345, 16'h0, 2'b11, 16'hBE34);
        repeat (20) @(negedge clk);
        check("final_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
